// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver:
// state encodings, line idle level, parity mode and a counter width helper.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    // XOR-ed into the data parity; 0 gives even parity over data plus parity bit.
    localparam logic PARITY_MODE = 1'b0;

    // A one-value counter still needs a one-bit register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit period timer: ticks in the last cycle of every CLKS_PER_BIT-cycle period,
// restarting from zero whenever clear is held.
module serial_frame_tx_bit_timer
    import serial_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, data LSB first, optional even parity, stop bit.
// The line is registered and idles high; a new word is taken on start && ready.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  start,
    output logic                  ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = cnt_width(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [IDX_W-1:0]      bit_idx;
    logic                  parity_q;
    logic                  tx_q;
    logic                  tx_next;
    logic                  tick;
    logic                  accept;

    assign accept = start && (state == ST_IDLE);

    // The timer is held at zero while idle so the start bit gets a full period.
    serial_frame_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock(clock),
        .reset(reset),
        .clear(state == ST_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_START;
            ST_START:  if (tick) state_next = ST_DATA;
            ST_DATA: begin
                if (tick && (bit_idx == LAST_IDX)) begin
                    state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (tick) state_next = ST_STOP;
            ST_STOP:   if (tick) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // The line value is chosen from the upcoming state so tx_out can be a flop.
    always_comb begin
        shift_next = shift_q;
        tx_next    = LINE_IDLE;
        if (accept) begin
            shift_next = data;
        end else if ((state == ST_DATA) && tick) begin
            shift_next = shift_q >> 1;
        end
        case (state_next)
            ST_IDLE:   tx_next = LINE_IDLE;
            ST_START:  tx_next = ~LINE_IDLE;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = parity_q;
            ST_STOP:   tx_next = LINE_IDLE;
            default:   tx_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            bit_idx  <= '0;
            parity_q <= 1'b0;
            tx_q     <= LINE_IDLE;
        end else begin
            shift_q <= shift_next;
            tx_q    <= tx_next;
            if (accept) begin
                bit_idx  <= '0;
                parity_q <= (^data) ^ PARITY_MODE;
            end else if ((state == ST_DATA) && tick) begin
                bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
            end
        end
    end

    assign tx_out = tx_q;
    assign ready  = (state == ST_IDLE);
    assign busy   = ~ready;
    assign done   = (state == ST_STOP) && tick;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: table of frames plus hand sequences for glitches,
// back-to-back requests, mid-frame reset and a parity-free build.
module tb_serial_frame_tx;

    typedef struct {
        logic tx;
        logic done;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         glitch_cycle;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data = 8'h00;
    logic       start = 1'b0;
    logic       ready, tx_out, busy, done;
    logic [7:0] data_np = 8'h00;
    logic       start_np = 1'b0;
    logic       ready_np, tx_np, busy_np, done_np;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clock = ~clock;

    serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
        .clock(clock), .reset(reset), .data(data), .start(start),
        .ready(ready), .tx_out(tx_out), .busy(busy), .done(done)
    );

    serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_np (
        .clock(clock), .reset(reset), .data(data_np), .start(start_np),
        .ready(ready_np), .tx_out(tx_np), .busy(busy_np), .done(done_np)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line, one entry per clock: start, data LSB first, parity, stop.
    task automatic push_frame(input logic [7:0] d, input logic par, input bit with_par);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (with_par) bits.push_back(par);
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < 4; c++) begin
                exp_q.push_back('{tx: bits[b], done: ((b == bits.size() - 1) && (c == 3))});
            end
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input bit np, input logic par);
        @(negedge clock);
        if (np) begin
            data_np = d;
            start_np = 1'b1;
        end else begin
            data = d;
            start = 1'b1;
        end
        push_frame(d, par, !np);
    endtask

    task automatic drain_frame(input string name, input bit np, input bit hold_start,
                               input logic [7:0] next_data, input int glitch_cycle,
                               input int abort_cycle);
        int cyc = 0;
        while (exp_q.size() > 0) begin
            exp_t e;
            @(negedge clock);
            cyc++;
            e = exp_q.pop_front();
            check_output({name, " tx"}, np ? tx_np : tx_out, e.tx);
            check_output({name, " done"}, np ? done_np : done, e.done);
            check_output({name, " busy"}, np ? busy_np : busy, 1);
            if (cyc == 1) begin
                if (!hold_start) begin
                    start = 1'b0;
                    start_np = 1'b0;
                end
                data = next_data;
            end
            if (cyc == glitch_cycle) begin
                data = 8'hFF;
                start = 1'b1;
            end
            if (cyc == glitch_cycle + 1) start = 1'b0;
            if (cyc == abort_cycle) begin
                #1 reset = 1'b1;
                #1;
                check_output({name, " abort tx"}, tx_out, 1);
                check_output({name, " abort ready"}, ready, 1);
                check_output({name, " abort done"}, done, 0);
                exp_q.delete();
            end
        end
    endtask

    task automatic check_idle(input string name, input bit np, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check_output({name, " idle ready"}, np ? ready_np : ready, 1);
            check_output({name, " idle tx"}, np ? tx_np : tx_out, 1);
            check_output({name, " idle busy"}, np ? busy_np : busy, 0);
        end
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{data: 8'hA5, par: 1'b0, glitch_cycle: -1};
        vecs[1] = '{data: 8'h07, par: 1'b1, glitch_cycle: -1};
        vecs[2] = '{data: 8'h00, par: 1'b0, glitch_cycle: -1};
        vecs[3] = '{data: 8'hFF, par: 1'b0, glitch_cycle: -1};
        vecs[4] = '{data: 8'h3C, par: 1'b0, glitch_cycle: 10};

        #2 reset = 1'b1;
        #1;
        check_output("reset tx", tx_out, 1);
        check_output("reset ready", ready, 1);
        check_output("reset done", done, 0);
        check_output("reset busy", busy, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_idle("post reset", 0, 3);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].data, 0, vecs[i].par);
            drain_frame($sformatf("frame %0h", vecs[i].data), 0, 0, vecs[i].data,
                        vecs[i].glitch_cycle, -1);
            check_idle($sformatf("frame %0h", vecs[i].data), 0,
                       (vecs[i].glitch_cycle > 0) ? 6 : 1);
        end

        apply_stimulus(8'h07, 1, 1'b0);
        drain_frame("nopar 07", 1, 0, 8'h00, -1, -1);
        check_idle("nopar 07", 1, 2);

        apply_stimulus(8'h01, 0, 1'b1);
        drain_frame("b2b 01", 0, 1, 8'h80, -1, -1);
        @(negedge clock);
        check_output("b2b gap ready", ready, 1);
        check_output("b2b gap tx", tx_out, 1);
        push_frame(8'h80, 1'b1, 1);
        drain_frame("b2b 80", 0, 0, 8'h80, -1, -1);
        check_idle("b2b 80", 0, 2);

        apply_stimulus(8'hA5, 0, 1'b0);
        drain_frame("abort a5", 0, 0, 8'hA5, -1, 18);
        @(negedge clock);
        check_output("abort held ready", ready, 1);
        check_output("abort held tx", tx_out, 1);
        reset = 1'b0;
        check_idle("after abort", 0, 2);
        apply_stimulus(8'hA5, 0, 1'b0);
        drain_frame("clean a5", 0, 0, 8'hA5, -1, -1);
        check_idle("clean a5", 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
